// File: rtl/iopad_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iopad_bank_pkg
// Purpose  : Shared mode-word layout for the iopad_bank_cfg GPIO bank.
//            Optional loopback bit controlled by IOPAD_BANK_LOOPBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
package iopad_bank_pkg;

  // Mode word layout: one word per pad, pad N-1 sits at the top of the chain.
`ifdef IOPAD_BANK_LOOPBACK_EN
  localparam int CFG_W     = 4;
  localparam int CFG_DIR   = 0;
  localparam int CFG_OREG  = 1;
  localparam int CFG_ISYNC = 2;
  localparam int CFG_LPBK  = 3;
`else
  localparam int CFG_W     = 3;
  localparam int CFG_DIR   = 0;
  localparam int CFG_OREG  = 1;
  localparam int CFG_ISYNC = 2;
`endif

  typedef logic [CFG_W-1:0] pad_mode_t;

  // Total chain length for a bank of num_pads pads.
  function automatic int chain_len(input int num_pads);
    return num_pads * CFG_W;
  endfunction

endpackage : iopad_bank_pkg
`default_nettype wire

// File: rtl/iopad_bank_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : iopad_bank_cfg_if
// Purpose  : Serial configuration chain bundle (data, shift, load, status).
//            master = chain driver (previous tile / controller),
//            slave  = the pad bank.
// Revision : 1.0  initial release
// ============================================================================
interface iopad_bank_cfg_if;

  logic ccff_head;
  logic ccff_tail;
  logic cfg_shift;
  logic cfg_load;
  logic cfg_ready;
  logic cfg_err;

  modport master (
    output ccff_head,
    output cfg_shift,
    output cfg_load,
    input  ccff_tail,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  ccff_head,
    input  cfg_shift,
    input  cfg_load,
    output ccff_tail,
    output cfg_ready,
    output cfg_err
  );

endinterface : iopad_bank_cfg_if
`default_nettype wire

// File: rtl/iopad_bank_cfg_chain.sv
`default_nettype none
// ============================================================================
// Module   : iopad_bank_cfg_chain
// Purpose  : Shadow shift register, shift counter, load/error control and
//            the active mode register that actually steers the pads.
//            Chain width follows IOPAD_BANK_LOOPBACK_EN through CFG_W.
// Revision : 1.0  initial release
// ============================================================================
module iopad_bank_cfg_chain
  import iopad_bank_pkg::*;
#(
  parameter int TOTAL = 24
) (
  input  wire logic             prog_clk,
  input  wire logic             prog_reset_n,
  iopad_bank_cfg_if.slave       cfg,
  output logic [TOTAL-1:0]      active
);

  localparam int               CNT_W   = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

  logic [TOTAL-1:0] shadow;
  logic [CNT_W-1:0] shift_cnt;
  logic             ready;
  logic             load_ok;
  logic             load_bad;
  logic             err_q;

  // Ready only after exactly a full word has gone in since reset/load;
  // the counter saturates so over-shifting keeps it asserted.
  assign ready    = (shift_cnt == CNT_MAX);

  // A load is honoured only when the chain is full and not moving this
  // cycle; anything else is flagged and leaves the active word alone.
  assign load_ok  = cfg.cfg_load & ready & ~cfg.cfg_shift;
  assign load_bad = cfg.cfg_load & ~load_ok;

  // Shadow shift register: first bit in ends up at the MSB after TOTAL shifts.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow <= '0;
    end else if (cfg.cfg_shift) begin
      shadow <= {shadow[TOTAL-2:0], cfg.ccff_head};
    end
  end

  // Shift counter: cleared by a legal load, otherwise saturating count of shifts.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shift_cnt <= '0;
    end else if (load_ok) begin
      shift_cnt <= '0;
    end else if (cfg.cfg_shift && !ready) begin
      shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Active register: only a legal load copies the shadow across.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      active <= '0;
    end else if (load_ok) begin
      active <= shadow;
    end
  end

  // Error flag: single-cycle pulse for every rejected load request.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= load_bad;
    end
  end

  assign cfg.ccff_tail = shadow[TOTAL-1];
  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_q;

endmodule : iopad_bank_cfg_chain
`default_nettype wire

// File: rtl/iopad_bank_cfg.sv
`default_nettype none
// ============================================================================
// Module   : iopad_bank_cfg
// Purpose  : Bank of NUM_PADS bidirectional GPIO pads with per-pad mode
//            (direction, registered output, input synchroniser) loaded
//            through a glitch-free shadow/active serial config chain.
//            Define IOPAD_BANK_LOOPBACK_EN to add a per-pad loopback bit.
// Revision : 1.0  initial release
// ============================================================================
module iopad_bank_cfg
  import iopad_bank_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                prog_clk,
  input  wire logic                prog_reset_n,
  inout  wire       [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  wire logic [NUM_PADS-1:0] iopad_outpad,
  output wire logic [NUM_PADS-1:0] iopad_inpad,
  iopad_bank_cfg_if.slave          cfg
);

  localparam int TOTAL = chain_len(NUM_PADS);

  logic [TOTAL-1:0] active;

  iopad_bank_cfg_chain #(
    .TOTAL (TOTAL)
  ) u_chain (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .cfg          (cfg),
    .active       (active)
  );

  // One datapath per pad; pad i takes mode bits [i*CFG_W +: CFG_W].
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_mode_t              mode;
    logic                   o_q;
    logic [SYNC_STAGES-1:0] sync;
    logic                   o_data;
    logic                   in_src;
    logic                   drive;

    assign mode   = active[i*CFG_W +: CFG_W];
    assign o_data = mode[CFG_OREG] ? o_q : iopad_outpad[i];

`ifdef IOPAD_BANK_LOOPBACK_EN
    // Loopback steers the output value straight into the input path and
    // parks the physical pad so nothing external sees the test traffic.
    assign in_src = mode[CFG_LPBK] ? o_data : gfpga_pad_GPIO_PAD[i];
    assign drive  = mode[CFG_DIR] & ~mode[CFG_LPBK];
`else
    assign in_src = gfpga_pad_GPIO_PAD[i];
    assign drive  = mode[CFG_DIR];
`endif

    assign gfpga_pad_GPIO_PAD[i] = drive ? o_data : 1'bz;
    assign iopad_inpad[i]        = mode[CFG_ISYNC] ? sync[SYNC_STAGES-1] : in_src;

    // Output flop and input synchroniser run in every mode so that turning
    // OREG/ISYNC on exposes current data rather than a stale value.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
        o_q  <= 1'b0;
        sync <= '0;
      end else begin
        o_q  <= iopad_outpad[i];
        sync <= {sync[SYNC_STAGES-2:0], in_src};
      end
    end
  end : g_pad

endmodule : iopad_bank_cfg
`default_nettype wire

// File: tb/tb_iopad_bank_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_iopad_bank_cfg
// Purpose  : Self-checking bench for iopad_bank_cfg (NUM_PADS=8,
//            SYNC_STAGES=2). Loopback checks run when IOPAD_BANK_LOOPBACK_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_iopad_bank_cfg;

  localparam int NP = 8;
`ifdef IOPAD_BANK_LOOPBACK_EN
  localparam int BW = 4;
`else
  localparam int BW = 3;
`endif
  localparam int TOT = NP * BW;

  logic          prog_clk;
  logic          prog_reset_n;
  logic [NP-1:0] outpad;
  wire  [NP-1:0] inpad;
  wire  [NP-1:0] pad;
  logic [NP-1:0] tb_en;
  logic [NP-1:0] tb_val;

  iopad_bank_cfg_if cfg_bus ();

  iopad_bank_cfg #(
    .NUM_PADS    (NP),
    .SYNC_STAGES (2)
  ) dut (
    .prog_clk           (prog_clk),
    .prog_reset_n       (prog_reset_n),
    .gfpga_pad_GPIO_PAD (pad),
    .iopad_outpad       (outpad),
    .iopad_inpad        (inpad),
    .cfg                (cfg_bus)
  );

  // External pad drivers (the board side of the pads).
  for (genvar g = 0; g < NP; g++) begin : g_ext
    assign pad[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end : g_ext

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [NP-1:0] en;
    logic [NP-1:0] val;
    logic [NP-1:0] out;
    logic [NP-1:0] exp_in;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_check(input logic [7:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_underflow: got %h expected <entry>", act);
    end else begin
      e = sb.pop_front();
      check(e.name, {24'h0, act}, {24'h0, e.exp});
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [BW-1:0] md(input bit dir, input bit oreg, input bit isync, input bit lpbk);
    logic [BW-1:0] m;
    m    = '0;
    m[0] = dir;
    m[1] = oreg;
    m[2] = isync;
`ifdef IOPAD_BANK_LOOPBACK_EN
    m[3] = lpbk;
`else
    if (lpbk) m[0] = dir;
`endif
    return m;
  endfunction

  function automatic logic [TOT-1:0] mk(input int p, input logic [BW-1:0] m);
    logic [TOT-1:0] w;
    w = '0;
    w[p*BW +: BW] = m;
    return w;
  endfunction

  task automatic shift_bits(input logic [TOT-1:0] w, input int nbits);
    for (int k = nbits - 1; k >= 0; k--) begin
      cfg_bus.ccff_head = w[k];
      cfg_bus.cfg_shift = 1'b1;
      tick();
    end
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.ccff_head = 1'b0;
  endtask

  task automatic pulse_load();
    cfg_bus.cfg_load = 1'b1;
    tick();
    cfg_bus.cfg_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    logic       b;

    vecs[0] = '{8'hFF, 8'hA5, 8'h5A, 8'hA5};
    vecs[1] = '{8'hFF, 8'h3C, 8'hFF, 8'h3C};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};

    prog_reset_n      = 1'b0;
    outpad            = '0;
    tb_en             = '0;
    tb_val            = '0;
    cfg_bus.ccff_head = 1'b0;
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_load  = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'h0, cfg_bus.cfg_ready}, 32'h0);
    check("rst_tail",  {31'h0, cfg_bus.ccff_tail}, 32'h0);
    check("rst_err",   {31'h0, cfg_bus.cfg_err},   32'h0);
    prog_reset_n = 1'b1;
    tick();

    // Give pad0 a driving config, then reset in the middle of a new shift.
    shift_bits(mk(0, md(1, 1, 0, 0)), TOT);
    pulse_load();
    shift_bits({TOT{1'b1}}, TOT);
    check("pre_rst_ready", {31'h0, cfg_bus.cfg_ready}, 32'h1);
    check("pre_rst_tail",  {31'h0, cfg_bus.ccff_tail}, 32'h1);
    cfg_bus.ccff_head = 1'b1;
    cfg_bus.cfg_shift = 1'b1;
    prog_reset_n      = 1'b0;
    #1;
    check("midrst_ready", {31'h0, cfg_bus.cfg_ready}, 32'h0);
    check("midrst_tail",  {31'h0, cfg_bus.ccff_tail}, 32'h0);
    tick();
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.ccff_head = 1'b0;
    prog_reset_n      = 1'b1;
    tick();
    check("midrst_err", {31'h0, cfg_bus.cfg_err}, 32'h0);

    // All pads must now be hi-Z inputs with a combinational input path.
    for (int v = 0; v < 4; v++) begin
      tb_en  = vecs[v].en;
      tb_val = vecs[v].val;
      outpad = vecs[v].out;
      #1;
      check($sformatf("rst_inpad_v%0d", v), {24'h0, inpad}, {24'h0, vecs[v].exp_in});
    end
    tb_en = '0;

    // pad0 DIR+OREG: pad0 follows outpad one edge late, other pads untouched.
    shift_bits(mk(0, md(1, 1, 0, 0)), TOT);
    check("full_ready", {31'h0, cfg_bus.cfg_ready}, 32'h1);
    pulse_load();
    check("load_err",   {31'h0, cfg_bus.cfg_err},   32'h0);
    check("load_ready", {31'h0, cfg_bus.cfg_ready}, 32'h0);
    tb_en = 8'hFE;
    for (int c = 0; c < 8; c++) begin
      outpad = 8'($urandom);
      tb_val = 8'($urandom);
      sb.push_back('{"oreg_pad0", {7'h0, outpad[0]}});
      tick();
      e = {7'h0, pad[0]};
      sb_check(e);
      check("oreg_inpad0", {31'h0, inpad[0]}, {31'h0, pad[0]});
      check("oreg_in_others", {24'h0, inpad[7:1], 1'b0}, {24'h0, tb_val[7:1], 1'b0});
    end

    // Load attempted one bit short: rejected, mode kept.
    shift_bits('0, TOT - 1);
    pulse_load();
    check("short_err",   {31'h0, cfg_bus.cfg_err},   32'h1);
    check("short_ready", {31'h0, cfg_bus.cfg_ready}, 32'h0);
    outpad = 8'h01;
    sb.push_back('{"short_oreg_pad0", 8'h01});
    tick();
    check("short_err_drop", {31'h0, cfg_bus.cfg_err}, 32'h0);
    sb_check({7'h0, pad[0]});

    // Fill the last bit, then load together with a shift: rejected, shift happens.
    shift_bits('0, 1);
    check("full2_ready", {31'h0, cfg_bus.cfg_ready}, 32'h1);
    outpad            = 8'h00;
    cfg_bus.ccff_head = 1'b1;
    cfg_bus.cfg_shift = 1'b1;
    cfg_bus.cfg_load  = 1'b1;
    tick();
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_load  = 1'b0;
    cfg_bus.ccff_head = 1'b0;
    check("simul_err",   {31'h0, cfg_bus.cfg_err},   32'h1);
    check("simul_ready", {31'h0, cfg_bus.cfg_ready}, 32'h1);
    outpad = 8'h01;
    sb.push_back('{"simul_keep_oreg", 8'h01});
    tick();
    sb_check({7'h0, pad[0]});
    // Legal load now applies shadow = ...0001: pad0 DIR only, combinational.
    pulse_load();
    check("legal_err", {31'h0, cfg_bus.cfg_err}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      outpad = (c % 2 == 0) ? 8'hFF : 8'h00;
      #1;
      check("comb_pad0",   {31'h0, pad[0]},   {31'h0, outpad[0]});
      check("comb_inpad0", {31'h0, inpad[0]}, {31'h0, outpad[0]});
    end

    // pad1 ISYNC: input reaches fabric exactly two edges after the pad moves.
    shift_bits(mk(1, md(0, 0, 1, 0)), TOT);
    pulse_load();
    tb_en  = 8'hFF;
    tb_val = 8'h00;
    tick();
    tick();
    tick();
    check("sync_low", {31'h0, inpad[1]}, 32'h0);
    tb_val = 8'h02;
    #1;
    check("sync_hold0", {31'h0, inpad[1]}, 32'h0);
    tick();
    check("sync_edge1", {31'h0, inpad[1]}, 32'h0);
    tick();
    check("sync_edge2", {31'h0, inpad[1]}, 32'h1);
    for (int c = 0; c < 8; c++) begin
      b      = 1'($urandom);
      tb_val = {5'h0, 1'($urandom), b, 1'b0};
      sb.push_back('{"sync_pad1", {7'h0, b}});
      #1;
      check("nosync_pad2", {31'h0, inpad[2]}, {31'h0, tb_val[2]});
      tick();
      if (sb.size() == 2) sb_check({7'h0, inpad[1]});
    end
    sb.delete();

    // Chain pass-through: tail reproduces head TOT shifts later.
    for (int k = 0; k < TOT + 5; k++) begin
      b                 = 1'($urandom);
      cfg_bus.ccff_head = b;
      cfg_bus.cfg_shift = 1'b1;
      sb.push_back('{"chain_tail", {7'h0, b}});
      tick();
      if (sb.size() == TOT) sb_check({7'h0, cfg_bus.ccff_tail});
    end
    cfg_bus.cfg_shift = 1'b0;
    check("overshift_ready", {31'h0, cfg_bus.cfg_ready}, 32'h1);
    sb.delete();

`ifdef IOPAD_BANK_LOOPBACK_EN
    tb_en = 8'hF7;
    shift_bits(mk(3, md(1, 0, 0, 1)), TOT);
    pulse_load();
    outpad = 8'h08;
    #1;
    check("lpbk_in_hi",  {31'h0, inpad[3]}, 32'h1);
    check("lpbk_pad_z",  {31'h0, (pad[3] === 1'b1)}, 32'h0);
    outpad = 8'h00;
    #1;
    check("lpbk_in_lo",  {31'h0, inpad[3]}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_iopad_bank_cfg
`default_nettype wire
